// File: rtl/reg_file.sv
// reg_file: general-purpose register file for the CPU datapath.
//   2**ADDR_W registers of DATA_W bits, one synchronous write port,
//   one combinational read port. Register 0 is an ordinary register.
// Ports:
//   clk     system clock, writes on rising edge
//   rst_n   asynchronous active-low reset, clears all registers
//   w_en    write enable, sampled at rising edge
//   w_addr  write register index
//   w_data  write data
//   r_addr  read register index
//   r_data  combinational read data, reg[r_addr] (no write bypass)
module reg_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  localparam int unsigned N_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [N_REGS];

  // Storage: reset clears every entry immediately and overrides any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (w_en) begin
      regs[w_addr] <= w_data;
    end
  end

  // Read port: zero-latency, shows the pre-edge value for a same-cycle write.
  assign r_data = regs[r_addr];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized and directed scoreboard bench for reg_file.
module tb_reg_file;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned N_REGS = 2 ** ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_en   (w_en),
    .w_addr (w_addr),
    .w_data (w_data),
    .r_addr (r_addr),
    .r_data (r_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  event      chk_ev;
  int        n_checks = 0;
  int        n_pass   = 0;
  int        n_fail   = 0;

  // Reference model: plain array holding what each register must contain.
  logic [DATA_W-1:0] model [N_REGS];

  task automatic model_clear();
    for (int i = 0; i < int'(N_REGS); i++) model[i] = '0;
  endtask

  // Monitor: compares r_data against every expectation posted by the stimulus.
  initial begin
    sb_entry_t e;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (r_data !== e.exp) begin
          n_fail++;
          $display("FAIL %s: r_addr=%0d r_data=%h expected=%h at %0t",
                   e.name, e.addr, r_data, e.exp, $time);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Present an address, let it settle, then post the model's expectation.
  task automatic check_read(input logic [ADDR_W-1:0] a, input string nm);
    sb_entry_t e;
    r_addr = a;
    #1;
    e.name = nm;
    e.addr = a;
    e.exp  = model[a];
    sb_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  // One clocked write attempt; returns at posedge+1 with w_en dropped.
  task automatic do_write(input logic en, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    w_en   = en;
    w_addr = a;
    w_data = d;
    @(posedge clk);
    if (en && rst_n) model[a] = d;
    #1;
    w_en = 1'b0;
  endtask

  // Watchdog: the bench never waits on the DUT, but bound the run anyway.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic              en;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;

    rst_n  = 1'b0;
    w_en   = 1'b0;
    w_addr = '0;
    w_data = '0;
    r_addr = '0;
    model_clear();

    // Reset held: every register reads zero.
    #1;
    for (int i = 0; i < int'(N_REGS); i++) check_read(ADDR_W'(i), "reset_held");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < int'(N_REGS); i++) check_read(ADDR_W'(i), "reset_released");

    // Write then read.
    do_write(1'b1, 3'd0, 16'd9);
    check_read(3'd0, "write_read_r0");

    // Write inputs active but no clock edge: nothing changes.
    w_en   = 1'b1;
    w_addr = 3'd0;
    w_data = 16'd0;
    check_read(3'd0, "no_edge_no_write");
    w_en = 1'b0;

    // Write disabled across an edge.
    do_write(1'b0, 3'd0, 16'd0);
    check_read(3'd0, "write_disabled");

    // Sweep, then re-read everything for cross-register corruption.
    for (int n = 0; n < int'(N_REGS); n++) begin
      do_write(1'b1, ADDR_W'(n), DATA_W'(n));
      check_read(ADDR_W'(n), "sweep_write");
    end
    for (int n = 0; n < int'(N_REGS); n++) check_read(ADDR_W'(n), "sweep_reread");

    // Same-address read: old value before the edge, new after (no bypass).
    w_en   = 1'b1;
    w_addr = 3'd3;
    w_data = 16'hBEEF;
    check_read(3'd3, "same_addr_before_edge");
    @(posedge clk);
    model[3] = 16'hBEEF;
    #1;
    w_en = 1'b0;
    check_read(3'd3, "same_addr_after_edge");

    // Async reset between edges with a pending write.
    w_en   = 1'b1;
    w_addr = 3'd5;
    w_data = 16'hAAAA;
    #1;
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < int'(N_REGS); i++) check_read(ADDR_W'(i), "async_reset_immediate");
    @(posedge clk);
    #1;
    check_read(3'd5, "write_during_reset_ignored");
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check_read(3'd5, "after_release_before_edge");
    @(posedge clk);
    model[5] = 16'hAAAA;
    #1;
    w_en = 1'b0;
    check_read(3'd5, "first_write_after_reset");
    check_read(3'd4, "first_write_no_spill");

    // Randomized traffic: read before and after each edge against the model.
    for (int k = 0; k < 300; k++) begin
      en = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, N_REGS - 1));
      d  = DATA_W'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? a : ADDR_W'($urandom_range(0, N_REGS - 1));
      w_en   = en;
      w_addr = a;
      w_data = d;
      check_read(ra, "rand_before_edge");
      @(posedge clk);
      if (en) model[a] = d;
      #1;
      w_en = 1'b0;
      check_read(ra, "rand_after_edge");
      check_read(a, "rand_write_addr");
    end

    for (int n = 0; n < int'(N_REGS); n++) check_read(ADDR_W'(n), "final_sweep");

    #2;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
